// File: rtl/mac_pkg.sv
// mac_pkg: types and default constants shared by the MAC sequencer slice.
//   state_t      sequencer control state (IDLE / RUN / DRAIN)
//   MUL_LAT_DEF  default fixed latency of the FP multiplier stage, in cycles
//   ADD_LAT_DEF  default fixed latency of the FP adder/accumulator stage, in cycles
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MUL_LAT_DEF = 3;
    localparam int ADD_LAT_DEF = 2;

endpackage

// File: rtl/mac_lat_tracker.sv
// mac_lat_tracker: fixed-depth valid/tag shift register that follows an
// operation through a pipeline of known latency.
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, empties the pipe
//   clear      synchronous clear, empties the pipe on the next edge
//   in_valid   an operation enters the pipe this cycle
//   in_tag     side-band flags travelling with the operation
//   out_valid  the operation that entered DEPTH cycles ago emerges now
//   out_tag    its flags
module mac_lat_tracker #(
    parameter int DEPTH = 1,
    parameter int TAG_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    // NOTE: the tag stages are reset along with the valid bits; they are only
    // a few flops, and it keeps X off out_tag even while out_valid is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else if (clear) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its neighbour held before the edge, which is what a shift needs.
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: control for a dot-product job on a pipelined FP multiplier
// feeding a single accumulating FP adder.
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   start, vec_len  begin a job of vec_len A/B pairs (sampled in IDLE only)
//   abort           cancel the running job
//   in_valid        an operand pair is offered
//   in_ready        the pair is accepted this cycle
//   mul_issue       multiplier captures the operands (in_valid & in_ready)
//   add_issue       adder consumes the product emerging from the multiplier
//   acc_zero        with add_issue: first product of the job, add to 0.0
//   busy            a job is in progress
//   result_valid    one-cycle pulse, accumulator holds the final sum
//   result_empty    with result_valid: the job had no pairs, result is 0.0
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int LEN_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mul_issue,
    output logic             add_issue,
    output logic             acc_zero,
    output logic             busy,
    output logic             result_valid,
    output logic             result_empty
);

    // Wide enough to hold ADD_LAT-1, never zero bits wide.
    localparam int SPC_W = ($clog2(ADD_LAT) > 0) ? $clog2(ADD_LAT) : 1;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [SPC_W-1:0] space_cnt, space_nxt;
    logic             first_done, first_done_nxt;
    logic             empty_q, empty_nxt;

    logic             accept;
    logic             kill;
    logic             mul_out_valid;
    logic [1:0]       mul_out_tag;     // [1] last product, [0] first product
    logic             add_out_valid;
    logic             add_out_last;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == RUN) && (remaining != '0) && (space_cnt == '0);
    assign accept    = in_valid & in_ready;
    assign mul_issue = accept;

    // An abort kills whatever would emerge in the abort cycle as well as
    // everything still in flight (trackers are cleared on the same edge).
    assign kill      = abort & busy;

    assign add_issue    = mul_out_valid & ~kill;
    assign acc_zero     = add_issue & mul_out_tag[0];
    assign result_valid = empty_q | (add_out_valid & add_out_last & ~kill);
    assign result_empty = empty_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            space_cnt  <= '0;
            first_done <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            space_cnt  <= space_nxt;
            first_done <= first_done_nxt;
            empty_q    <= empty_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        space_nxt      = (space_cnt != '0) ? space_cnt - 1'b1 : space_cnt;
        first_done_nxt = first_done;
        empty_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                // Abort outranks a simultaneous start.
                if (start && !abort) begin
                    if (vec_len == '0) begin
                        empty_nxt = 1'b1;
                    end else begin
                        state_nxt      = RUN;
                        remaining_nxt  = vec_len;
                        first_done_nxt = 1'b0;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    remaining_nxt  = remaining - 1'b1;
                    space_nxt      = SPC_W'(ADD_LAT - 1);
                    first_done_nxt = 1'b1;
                    if (remaining == LEN_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (add_out_valid && add_out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (kill) begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
            space_nxt     = '0;
        end
    end

    // Multiplier pipe: an accept emerges as add_issue MUL_LAT cycles later.
    mac_lat_tracker #(
        .DEPTH (MUL_LAT),
        .TAG_W (2)
    ) u_mul_trk (
        .clock     (clock),
        .reset     (reset),
        .clear     (kill),
        .in_valid  (accept),
        .in_tag    ({remaining == LEN_W'(1), ~first_done}),
        .out_valid (mul_out_valid),
        .out_tag   (mul_out_tag)
    );

    // Adder pipe: the last add becomes result_valid ADD_LAT cycles later.
    mac_lat_tracker #(
        .DEPTH (ADD_LAT),
        .TAG_W (1)
    ) u_add_trk (
        .clock     (clock),
        .reset     (reset),
        .clear     (kill),
        .in_valid  (add_issue),
        .in_tag    (mul_out_tag[1]),
        .out_valid (add_out_valid),
        .out_tag   (add_out_last)
    );

endmodule
